// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a two-entry skid buffer.
// Carries a payload plus a control field over a valid/ready handshake.
// in_ready is a flop output, so there is no combinational path from out_ready.
// Control fields read zero whenever their entry is absent.
// Flush is synchronous and discards both stored entries and any entry offered in the same cycle.
module pipe_stage_skid #(
    parameter int DATA_W              = 69,
    parameter int CTRL_W              = 2,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Occupancy state, encoded directly as {main valid, skid valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occupancy_q, occupancy_d;

    state_t state;
    logic   accept;
    logic   drain;

    assign state  = state_t'({main_v_q, skid_v_q});
    assign accept = in_valid & in_ready_q;
    assign drain  = main_v_q & out_ready;

    // Next-state logic.
    // Hold is the default.
    // Flush overrides any handshake activity.
    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        // Downstream is stalled, so the new entry parks in the skid register.
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (drain) begin
                        // The stage becomes empty, so the control field is cleared to a bubble.
                        main_v_d    = 1'b0;
                        main_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_v_d    = 1'b0;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    // Unreachable encoding.
                    // Recover to EMPTY with bubble control fields.
                    main_v_d    = 1'b0;
                    skid_v_d    = 1'b0;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = ~skid_v_d;
        occupancy_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
    end

    // State registers.
    // Reset is asynchronous and leaves the stage empty but ready to accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
// Two instances share all inputs: one clears its data on flush, the other keeps it.
// The reference model is a FIFO queue of at most two entries.
module tb_pipe_stage_skid;

    localparam int DW = 69;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    logic          nc_in_ready, nc_out_valid;
    logic [DW-1:0] nc_out_data;
    logic [CW-1:0] nc_out_ctrl;
    logic [1:0]    nc_occupancy;

    int tests_run = 0;
    int tests_failed = 0;

    ent_t          mq[$];
    logic [DW-1:0] last_c = '0;
    logic [DW-1:0] last_n = '0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA_ON_FLUSH(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data), .out_ctrl(nc_out_ctrl),
        .occupancy(nc_occupancy)
    );

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic model_reset();
        mq.delete();
        last_c = '0;
        last_n = '0;
    endtask

    // Advance one clock edge and update the FIFO model with the inputs seen at that edge.
    task automatic tick();
        bit acc, drn;
        @(posedge clk);
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready;
        if (flush) begin
            mq.delete();
            last_c = '0;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back('{data: in_data, ctrl: in_ctrl});
        end
        if (mq.size() > 0) begin
            last_c = mq[0].data;
            last_n = mq[0].data;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        tests_run++; if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        tests_run++; if (out_data !== '0 || out_ctrl !== '0) begin tests_failed++; $display("FAIL reset_out: got data=%0h ctrl=%0b expected 0/0", out_data, out_ctrl); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset done");
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DW'(i), 2'b01, 1'b1, 1'b0);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== DW'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_%0d: got v=%0b d=%0h occ=%0d rdy=%0b expected v=1 d=%0h occ=1 rdy=1",
                         i, out_valid, out_data, occupancy, in_ready, i);
            end
            $display("[TB] stream entry %0d out_data=%0h", i, out_data);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin tests_failed++; $display("FAIL stream_drain: got v=%0b occ=%0d expected 0/0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, DW'('hA), 2'b10, 1'b0, 1'b0);
        tick();
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== DW'('hA)) begin tests_failed++; $display("FAIL bp_first: got occ=%0d rdy=%0b d=%0h expected 1/1/a", occupancy, in_ready, out_data); end
        drive(1'b1, DW'('hB), 2'b01, 1'b0, 1'b0);
        tick();
        tests_run++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== DW'('hA) || out_ctrl !== 2'b10) begin tests_failed++; $display("FAIL bp_full: got occ=%0d rdy=%0b d=%0h c=%0b expected 2/0/a/10", occupancy, in_ready, out_data, out_ctrl); end
        drive(1'b1, DW'('hD), 2'b11, 1'b0, 1'b0);
        tick();
        tests_run++; if (occupancy !== 2'd2 || out_data !== DW'('hA) || out_ctrl !== 2'b10) begin tests_failed++; $display("FAIL bp_hold: got occ=%0d d=%0h c=%0b expected 2/a/10", occupancy, out_data, out_ctrl); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tests_run++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== DW'('hB) || out_ctrl !== 2'b01) begin tests_failed++; $display("FAIL bp_release: got occ=%0d rdy=%0b d=%0h c=%0b expected 1/1/b/01", occupancy, in_ready, out_data, out_ctrl); end
        tick();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 2'b00) begin tests_failed++; $display("FAIL bp_empty: got occ=%0d v=%0b c=%0b expected 0/0/00", occupancy, out_valid, out_ctrl); end
        $display("[TB] back-pressure sequence done occ=%0d", occupancy);
    endtask

    task automatic test_bubble();
        drive(1'b1, DW'('h77), 2'b11, 1'b1, 1'b0);
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_ctrl !== 2'b11) begin tests_failed++; $display("FAIL bubble_present: got v=%0b c=%0b expected 1/11", out_valid, out_ctrl); end
        drive(1'b0, '0, 2'b11, 1'b1, 1'b0);
        tick();
        tests_run++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00) begin tests_failed++; $display("FAIL bubble_clear: got v=%0b c=%0b expected 0/00", out_valid, out_ctrl); end
        $display("[TB] bubble ctrl=%0b", out_ctrl);
    endtask

    task automatic test_flush_full();
        drive(1'b1, DW'('h1), 2'b11, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'('h2), 2'b11, 1'b0, 1'b0);
        tick();
        tests_run++; if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_prefill: got occ=%0d expected 2", occupancy); end
        drive(1'b1, DW'('hC), 2'b11, 1'b1, 1'b1);
        tick();
        tests_run++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== '0) begin tests_failed++; $display("FAIL flush_full: got occ=%0d v=%0b c=%0b d=%0h expected 0/0/00/0", occupancy, out_valid, out_ctrl, out_data); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready: got %0b expected 1", in_ready); end
        tests_run++; if (nc_out_data !== DW'('h1) || nc_out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_keep_full: got d=%0h v=%0b expected 1/0", nc_out_data, nc_out_valid); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (out_valid !== 1'b0 || out_data === DW'('hC)) begin tests_failed++; $display("FAIL flush_discard: got v=%0b d=%0h expected v=0 and no 0xc", out_valid, out_data); end
        end
        $display("[TB] flush in FULL done");
    endtask

    task automatic test_flush_noclear();
        drive(1'b1, DW'('h5), 2'b01, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tests_run++; if (nc_out_valid !== 1'b0 || nc_out_ctrl !== 2'b00 || nc_out_data !== DW'('h5)) begin tests_failed++; $display("FAIL flush_noclear: got v=%0b c=%0b d=%0h expected 0/00/5", nc_out_valid, nc_out_ctrl, nc_out_data); end
        tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL flush_clear: got d=%0h expected 0", out_data); end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        $display("[TB] flush without clear out_data=%0h", nc_out_data);
    endtask

    task automatic test_async_reset();
        drive(1'b1, DW'('h31), 2'b11, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'('h32), 2'b10, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 2'b00 || out_data !== '0 || nc_out_data !== '0) begin tests_failed++; $display("FAIL async_reset: got v=%0b occ=%0d c=%0b d=%0h expected all 0", out_valid, occupancy, out_ctrl, out_data); end
        #1;
        rst = 1'b0;
        drive(1'b1, DW'('h44), 2'b01, 1'b1, 1'b0);
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_data !== DW'('h44) || occupancy !== 2'd1) begin tests_failed++; $display("FAIL async_reset_restart: got v=%0b d=%0h occ=%0d expected 1/44/1", out_valid, out_data, occupancy); end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        $display("[TB] async reset mid-stall done");
    endtask

    task automatic test_random();
        logic [95:0] r;
        for (int n = 0; n < 400; n++) begin
            r = {$urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 3) != 0), r[DW-1:0], 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            tick();
            tests_run++;
            if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size())) begin
                tests_failed++;
                $display("FAIL rand_hs_%0d: got rdy=%0b v=%0b occ=%0d expected occ=%0d", n, in_ready, out_valid, occupancy, mq.size());
            end
            tests_run++;
            if (out_data !== last_c || out_ctrl !== ((mq.size() > 0) ? mq[0].ctrl : 2'b00)) begin
                tests_failed++;
                $display("FAIL rand_out_%0d: got d=%0h c=%0b expected d=%0h", n, out_data, out_ctrl, last_c);
            end
            tests_run++;
            if (nc_out_data !== last_n || nc_occupancy !== 2'(mq.size())) begin
                tests_failed++;
                $display("FAIL rand_nc_%0d: got d=%0h occ=%0d expected d=%0h occ=%0d", n, nc_out_data, nc_occupancy, last_n, mq.size());
            end
            $display("[TB] rand %0d v=%0b rdy=%0b occ=%0d d=%0h", n, out_valid, in_ready, occupancy, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush_full();
        test_flush_noclear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
